uart_transmit: RTL and testbench

//  Serial UART transmitter; the send-side counterpart of the board's UART receive path.
//  - Accepts bytes over a valid/ready handshake into a small FIFO.
//  - Serialises each byte as an 8N1 frame: start bit, 8 data bits LSB first, stop bit(s).
//  - Sits between the game/control logic and the board TX pin.
//  - Bit timing is a fixed count of system clocks per bit.

---
 rtl/uart_transmit_if.sv | 26 ++
 rtl/uart_transmit.sv | 196 +++++++++++++++++++
 tb/tb_uart_transmit.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmit_if.sv
// Byte-push handshake and serial line status between the control logic and uart_transmit.
interface uart_transmit_if;
    logic [7:0] txdata;
    logic       txvalid;
    logic       txready;
    logic       tx;
    logic       txbusy;

    // Producer side: offers bytes and observes the line.
    modport master (
        output txdata,
        output txvalid,
        input  txready,
        input  tx,
        input  txbusy
    );

    // Transmitter side.
    modport slave (
        input  txdata,
        input  txvalid,
        output txready,
        output tx,
        output txbusy
    );
endinterface

// File: rtl/uart_transmit.sv
// UART transmitter: byte FIFO feeding an 8N1 serialiser with a fixed clocks-per-bit timer.
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit after data bit 7
// (even parity unless PARITY_ODD is 1). Without it, PARITY_ODD has no effect.
module uart_transmit #(
    parameter int unsigned CLOCKS_PER_BIT = 5208,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned STOP_BITS      = 1,
    parameter int unsigned PARITY_ODD     = 0
) (
    input  logic           clock,
    input  logic           reset,
    uart_transmit_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLOCKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fifo_count;
    logic             fifo_full_c;
    logic             fifo_nonempty_c;
    logic [7:0]       fifo_head_c;
    logic             push_c;
    logic             pop_c;
    logic             bit_done_c;
    logic             last_stop_c;

    state_t           state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             tx_q;
`ifdef UART_TX_PARITY_EN
    logic             parity_q;
`else
    logic             unused_parity_odd;
    assign unused_parity_odd = 1'(PARITY_ODD);
`endif

    // Handshake and status derived from registered state; a same-cycle pop never frees space.
    assign fifo_full_c     = (fifo_count == (PTR_W + 1)'(FIFO_DEPTH));
    assign fifo_nonempty_c = (fifo_count != '0);
    assign fifo_head_c     = fifo_mem[rd_ptr];
    assign push_c          = bus.txvalid & ~fifo_full_c;
    assign bit_done_c      = (clk_cnt == '0);
    assign last_stop_c     = (bit_idx == 3'(STOP_BITS - 1));

    assign bus.txready = ~fifo_full_c;
    assign bus.tx      = tx_q;
    assign bus.txbusy  = (state != IDLE) | fifo_nonempty_c;

    // Pop when idle, or on the final stop-bit cycle so frames run back to back.
    always_comb begin
        pop_c = 1'b0;
        case (state)
            IDLE:    pop_c = fifo_nonempty_c;
            STOP:    pop_c = bit_done_c & last_stop_c & fifo_nonempty_c;
            default: pop_c = 1'b0;
        endcase
    end

    // FIFO storage; the byte is captured only at the push edge.
    always_ff @(posedge clock) begin
        if (push_c) begin
            fifo_mem[wr_ptr] <= bus.txdata;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Frame sequencer: start, data LSB first, optional parity, stop bit(s).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tx_q     <= 1'b1;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop_c) begin
                        shreg    <= fifo_head_c;
`ifdef UART_TX_PARITY_EN
                        parity_q <= (^fifo_head_c) ^ 1'(PARITY_ODD);
`endif
                        tx_q     <= 1'b0;
                        clk_cnt  <= CNT_LOAD;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_done_c) begin
                        tx_q    <= shreg[0];
                        bit_idx <= '0;
                        clk_cnt <= CNT_LOAD;
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt - CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_done_c) begin
                        clk_cnt <= CNT_LOAD;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state   <= PARITY;
`else
                            tx_q    <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= shreg >> 1;
                            tx_q    <= shreg[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt - CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done_c) begin
                        tx_q    <= 1'b1;
                        bit_idx <= '0;
                        clk_cnt <= CNT_LOAD;
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt - CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_done_c) begin
                        clk_cnt <= CNT_LOAD;
                        if (last_stop_c) begin
                            bit_idx <= '0;
                            if (pop_c) begin
                                shreg    <= fifo_head_c;
`ifdef UART_TX_PARITY_EN
                                parity_q <= (^fifo_head_c) ^ 1'(PARITY_ODD);
`endif
                                tx_q     <= 1'b0;
                                state    <= START;
                            end else begin
                                tx_q  <= 1'b1;
                                state <= IDLE;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    tx_q  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_transmit.sv
// Self-checking bench for uart_transmit (CLOCKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_uart_transmit;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME1 = (10 + PAR) * CPB;
    localparam int FRAME2 = (11 + PAR) * CPB;

    logic clock;
    logic reset;
    int   n_pass;
    int   n_total;

    int         acc_q[$];
    logic [7:0] rnd_q[$];

    uart_transmit_if bus();
    uart_transmit_if bus2();

    uart_transmit #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH(4), .STOP_BITS(1), .PARITY_ODD(0)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );
    uart_transmit #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH(4), .STOP_BITS(2), .PARITY_ODD(0)) dut2 (
        .clock(clock), .reset(reset), .bus(bus2)
    );
`ifdef UART_TX_PARITY_EN
    uart_transmit_if bus3();
    uart_transmit #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH(4), .STOP_BITS(1), .PARITY_ODD(1)) dut3 (
        .clock(clock), .reset(reset), .bus(bus3)
    );
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected line level i cycles after the start edge of a frame carrying b.
    function automatic logic exp_level(input logic [7:0] b, input int i, input logic odd);
        int k;
        k = i / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (PAR == 1 && k == 9) return (^b) ^ odd;
        return 1'b1;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_total++; if (bus.tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", bus.tx); else n_pass++;
        n_total++; if (bus.txready !== 1'b1) $display("FAIL reset_txready: got %b want 1", bus.txready); else n_pass++;
        n_total++; if (bus.txbusy !== 1'b0) $display("FAIL reset_txbusy: got %b want 0", bus.txbusy); else n_pass++;
        reset = 1'b0;
        @(negedge clock);
        n_total++; if (bus.tx !== 1'b1) $display("FAIL post_reset_tx: got %b want 1", bus.tx); else n_pass++;
        n_total++; if (bus.txbusy !== 1'b0) $display("FAIL post_reset_txbusy: got %b want 0", bus.txbusy); else n_pass++;
    endtask

    task automatic test_single(input logic [7:0] b);
        logic e;
        @(negedge clock);
        n_total++; if (bus.txready !== 1'b1) $display("FAIL single_ready %h: got %b want 1", b, bus.txready); else n_pass++;
        bus.txdata  = b;
        bus.txvalid = 1'b1;
        @(negedge clock);
        bus.txvalid = 1'b0;
        bus.txdata  = ~b;
        n_total++; if (bus.tx !== 1'b1) $display("FAIL single_latency %h: tx=%b want 1", b, bus.tx); else n_pass++;
        n_total++; if (bus.txbusy !== 1'b1) $display("FAIL single_busy_queued %h: got %b want 1", b, bus.txbusy); else n_pass++;
        for (int i = 0; i < FRAME1; i++) begin
            @(negedge clock);
            e = exp_level(b, i, 1'b0);
            n_total++; if (bus.tx !== e) $display("FAIL single_frame %h cyc %0d: tx=%b want %b", b, i, bus.tx, e); else n_pass++;
        end
        n_total++; if (bus.txbusy !== 1'b1) $display("FAIL single_busy_last %h: got %b want 1", b, bus.txbusy); else n_pass++;
        @(negedge clock);
        n_total++; if (bus.txbusy !== 1'b0) $display("FAIL single_busy_end %h: got %b want 0", b, bus.txbusy); else n_pass++;
        n_total++; if (bus.tx !== 1'b1) $display("FAIL single_idle %h: tx=%b want 1", b, bus.tx); else n_pass++;
    endtask

    // Bytes 1..6 offered continuously: FIFO fills, refuses while full, frames run gap-free.
    task automatic test_back_to_back();
        int want;
        acc_q.delete();
        fork
            begin
                int idx;
                idx = 0;
                for (int c = 0; c < 400 && idx < 6; c++) begin
                    @(negedge clock);
                    bus.txvalid = 1'b1;
                    bus.txdata  = 8'(idx + 1);
                    if (bus.txready === 1'b1) begin
                        acc_q.push_back(c);
                        idx++;
                    end
                end
                @(negedge clock);
                bus.txvalid = 1'b0;
            end
            begin
                logic e;
                repeat (2) @(negedge clock);
                for (int i = 0; i < 6 * FRAME1; i++) begin
                    @(negedge clock);
                    e = exp_level(8'(i / FRAME1 + 1), i % FRAME1, 1'b0);
                    n_total++; if (bus.tx !== e) $display("FAIL b2b_line cyc %0d: tx=%b want %b", i, bus.tx, e); else n_pass++;
                end
                @(negedge clock);
                n_total++; if (bus.txbusy !== 1'b0) $display("FAIL b2b_busy_end: got %b want 0", bus.txbusy); else n_pass++;
            end
        join
        n_total++; if (acc_q.size() !== 6) $display("FAIL b2b_accept_count: got %0d want 6", acc_q.size()); else n_pass++;
        for (int k = 0; k < acc_q.size() && k < 6; k++) begin
            want = (k < 5) ? k : 2 + FRAME1;
            n_total++; if (acc_q[k] !== want) $display("FAIL b2b_accept_cycle %0d: got %0d want %0d", k, acc_q[k], want); else n_pass++;
        end
    endtask

    task automatic test_stop_bits();
        logic e;
        @(negedge clock);
        bus2.txdata  = 8'hFF;
        bus2.txvalid = 1'b1;
        @(negedge clock);
        bus2.txvalid = 1'b0;
        for (int i = 0; i < FRAME2; i++) begin
            @(negedge clock);
            e = exp_level(8'hFF, i, 1'b0);
            n_total++; if (bus2.tx !== e) $display("FAIL stop2_frame cyc %0d: tx=%b want %b", i, bus2.tx, e); else n_pass++;
        end
        @(negedge clock);
        n_total++; if (bus2.txbusy !== 1'b0) $display("FAIL stop2_busy_end: got %b want 0", bus2.txbusy); else n_pass++;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic e;
        logic e3;
        @(negedge clock);
        bus.txdata = 8'h07;  bus.txvalid = 1'b1;
        bus3.txdata = 8'h07; bus3.txvalid = 1'b1;
        @(negedge clock);
        bus.txvalid = 1'b0; bus3.txvalid = 1'b0;
        for (int i = 0; i < FRAME1; i++) begin
            @(negedge clock);
            e  = exp_level(8'h07, i, 1'b0);
            e3 = exp_level(8'h07, i, 1'b1);
            n_total++; if (bus.tx !== e) $display("FAIL parity_even cyc %0d: tx=%b want %b", i, bus.tx, e); else n_pass++;
            n_total++; if (bus3.tx !== e3) $display("FAIL parity_odd cyc %0d: tx=%b want %b", i, bus3.tx, e3); else n_pass++;
        end
        @(negedge clock);
        n_total++; if (bus.txbusy !== 1'b0) $display("FAIL parity_busy_end: got %b want 0", bus.txbusy); else n_pass++;
    endtask
`endif

    task automatic test_reset_midframe();
        logic e;
        @(negedge clock);
        bus.txdata  = 8'hA3;
        bus.txvalid = 1'b1;
        @(negedge clock);
        bus.txdata  = 8'h3C;
        @(negedge clock);
        bus.txvalid = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (i > 0) @(negedge clock);
            e = exp_level(8'hA3, i, 1'b0);
            n_total++; if (bus.tx !== e) $display("FAIL abort_pre cyc %0d: tx=%b want %b", i, bus.tx, e); else n_pass++;
        end
        #1 reset = 1'b1;
        #1;
        n_total++; if (bus.tx !== 1'b1) $display("FAIL abort_tx_async: got %b want 1", bus.tx); else n_pass++;
        n_total++; if (bus.txbusy !== 1'b0) $display("FAIL abort_busy: got %b want 0", bus.txbusy); else n_pass++;
        n_total++; if (bus.txready !== 1'b1) $display("FAIL abort_ready: got %b want 1", bus.txready); else n_pass++;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3 * FRAME1; i++) begin
            @(negedge clock);
            n_total++;
            if (bus.tx !== 1'b1 || bus.txbusy !== 1'b0)
                $display("FAIL abort_quiet cyc %0d: tx=%b busy=%b want 1/0", i, bus.tx, bus.txbusy);
            else n_pass++;
        end
        test_single(8'h3C);
    endtask

    // Random bytes with random gaps; a line decoder compares against the accepted-byte queue.
    task automatic test_random(input int nbytes);
        rnd_q.delete();
        fork
            begin
                int sent;
                sent = 0;
                for (int c = 0; c < 20000 && sent < nbytes; c++) begin
                    @(negedge clock);
                    bus.txdata = 8'($urandom);
                    if (bus.txvalid === 1'b0 && $urandom_range(0, 15) != 0) begin
                        bus.txvalid = 1'b0;
                    end else begin
                        bus.txvalid = 1'b1;
                        if (bus.txready === 1'b1) begin
                            rnd_q.push_back(bus.txdata);
                            sent++;
                        end
                    end
                    if (bus.txvalid === 1'b1 && bus.txready === 1'b1) begin
                        @(negedge clock);
                        bus.txvalid = 1'b0;
                        bus.txdata  = 8'($urandom);
                        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 60)) @(negedge clock);
                    end
                end
                @(negedge clock);
                bus.txvalid = 1'b0;
            end
            begin
                logic [7:0] got;
                logic [7:0] want;
                for (int f = 0; f < nbytes; f++) begin
                    int w;
                    w = 0;
                    @(negedge clock);
                    while (bus.tx !== 1'b0 && w < 4000) begin
                        @(negedge clock);
                        w++;
                    end
                    if (w >= 4000) begin
                        n_total++;
                        $display("FAIL rand_timeout frame %0d: no start bit within %0d cycles", f, w);
                        break;
                    end
                    repeat (CPB / 2) @(negedge clock);
                    n_total++; if (bus.tx !== 1'b0) $display("FAIL rand_start %0d: tx=%b want 0", f, bus.tx); else n_pass++;
                    for (int k = 0; k < 8; k++) begin
                        repeat (CPB) @(negedge clock);
                        got[k] = bus.tx;
                    end
                    want = (rnd_q.size() > 0) ? rnd_q.pop_front() : ~got;
                    n_total++; if (got !== want) $display("FAIL rand_byte %0d: got %h want %h", f, got, want); else n_pass++;
                    if (PAR == 1) begin
                        repeat (CPB) @(negedge clock);
                        n_total++; if (bus.tx !== ^want) $display("FAIL rand_parity %0d: got %b want %b", f, bus.tx, ^want); else n_pass++;
                    end
                    repeat (CPB) @(negedge clock);
                    n_total++; if (bus.tx !== 1'b1) $display("FAIL rand_stop %0d: tx=%b want 1", f, bus.tx); else n_pass++;
                end
            end
        join
        for (int w = 0; w < 200 && bus.txbusy !== 1'b0; w++) @(negedge clock);
        n_total++; if (bus.txbusy !== 1'b0) $display("FAIL rand_drain: txbusy=%b want 0", bus.txbusy); else n_pass++;
        n_total++; if (rnd_q.size() !== 0) $display("FAIL rand_leftover: %0d bytes unsent want 0", rnd_q.size()); else n_pass++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b1;
        bus.txvalid = 1'b0;  bus.txdata = 8'h00;
        bus2.txvalid = 1'b0; bus2.txdata = 8'h00;
`ifdef UART_TX_PARITY_EN
        bus3.txvalid = 1'b0; bus3.txdata = 8'h00;
`endif
        test_reset();
        test_single(8'h55);
        test_single(8'($urandom));
        test_single(8'($urandom));
        test_back_to_back();
        test_stop_bits();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_midframe();
        test_random(10);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
